// File: rtl/word_tx.sv
// Serial word transmitter: valid/ready parallel load, start/data/stop framing.
// Define WORD_TX_PARITY_EN to add an even-parity bit between the data and the stop bit.
//
// state  | meaning
// IDLE   | line high, in_ready=1, waiting for in_valid
// START  | start bit (sout=0)
// DATA   | WIDTH data bits, order set by LSB_FIRST
// PARITY | even parity of the captured word (WORD_TX_PARITY_EN only)
// STOP   | stop bit (sout=1), done pulse

module word_tx #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef WORD_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             cur_bit;
  logic [WIDTH-1:0] shifted;

`ifdef WORD_TX_PARITY_EN
  logic par;
`endif

  // The outgoing bit always sits at the shift-out end of shreg.
  assign cur_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign shifted = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      in_ready <= 1'b1;
      sout     <= 1'b1;
      sframe   <= 1'b0;
      done     <= 1'b0;
`ifdef WORD_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= START;
            shreg    <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            sout     <= 1'b0;
            sframe   <= 1'b1;
`ifdef WORD_TX_PARITY_EN
            par      <= ^in_data;
`endif
          end
        end
        START: begin
          state <= DATA;
          sout  <= cur_bit;
          shreg <= shifted;
          cnt   <= '0;
        end
        DATA: begin
          if (cnt == LAST) begin
`ifdef WORD_TX_PARITY_EN
            state <= PARITY;
            sout  <= par;
`else
            state <= STOP;
            sout  <= 1'b1;
            done  <= 1'b1;
`endif
          end else begin
            cnt   <= cnt + 1'b1;
            sout  <= cur_bit;
            shreg <= shifted;
          end
        end
`ifdef WORD_TX_PARITY_EN
        PARITY: begin
          state <= STOP;
          sout  <= 1'b1;
          done  <= 1'b1;
        end
`endif
        STOP: begin
          state    <= IDLE;
          sout     <= 1'b1;
          sframe   <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          sout     <= 1'b1;
          sframe   <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_tx.sv
// Bench for word_tx: three instances (8-bit LSB-first, 8-bit MSB-first, 32-bit LSB-first)
// checked against directed tables, hand sequences and a randomized frame model.

module tb_word_tx;

  logic        clk;
  logic        reset_n;
  logic [2:0]  vld;
  logic [31:0] dat [3];
  logic [2:0]  rdy, so, sf, dn;

  int vectors    = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_q[$];
  bit expq[$];

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [7:0]  order;  // data bits in time order, bit 7 first on the wire
    bit          par;
  } vec_t;

  vec_t tbl[7];

`ifdef WORD_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  word_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u8l (
    .clk(clk), .reset_n(reset_n), .in_valid(vld[0]), .in_data(dat[0][7:0]),
    .in_ready(rdy[0]), .sout(so[0]), .sframe(sf[0]), .done(dn[0]));

  word_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u8m (
    .clk(clk), .reset_n(reset_n), .in_valid(vld[1]), .in_data(dat[1][7:0]),
    .in_ready(rdy[1]), .sout(so[1]), .sframe(sf[1]), .done(dn[1]));

  word_tx #(.WIDTH(32), .LSB_FIRST(1'b1)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(vld[2]), .in_data(dat[2]),
    .in_ready(rdy[2]), .sout(so[2]), .sframe(sf[2]), .done(dn[2]));

  initial begin
    clk = 1'b0;
    #10;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    if (reset_n === 1'b1 && vld[2] === 1'b1 && rdy[2] === 1'b1) acc_q.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, int idx, logic [3:0] act, logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got {sout,sframe,done,ready}=%b want %b at t=%0t",
               nm, idx, act, exp, $time);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] outs(int idx);
    return {so[idx], sf[idx], dn[idx], rdy[idx]};
  endfunction

  // Reference frame from the framing rules: start 0, data bits, optional even parity, stop 1.
  task automatic build_model(int idx, logic [31:0] d);
    int w;
    bit lsb;
    bit p;
    w   = (idx == 2) ? 32 : 8;
    lsb = (idx != 1);
    p   = 1'b0;
    expq.delete();
    expq.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      p = p ^ d[i];
      expq.push_back(lsb ? d[i] : d[w-1-i]);
    end
    if (PAR_BITS == 1) expq.push_back(p);
    expq.push_back(1'b1);
  endtask

  task automatic build_table(vec_t v);
    expq.delete();
    expq.push_back(1'b0);
    for (int i = 7; i >= 0; i--) expq.push_back(v.order[i]);
    if (PAR_BITS == 1) expq.push_back(v.par);
    expq.push_back(1'b1);
  endtask

  // Called right after the accept edge; checks every frame cycle plus the idle cycle after it.
  task automatic check_frame(int idx, logic [31:0] mid_d);
    int n;
    n = expq.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == n / 2) dat[idx] = mid_d;
      chk("frame_bit", idx, outs(idx), {expq[j], 1'b1, (j == n - 1), 1'b0});
    end
    @(negedge clk);
    chk("idle_after", idx, outs(idx), 4'b1001);
  endtask

  task automatic send(int idx, logic [31:0] d, bit hold);
    int n;
    @(negedge clk);
    vld[idx] = 1'b1;
    dat[idx] = d;
    n = 0;
    while (rdy[idx] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_wait dut%0d: got ready=%b want 1", idx, rdy[idx]);
    end
    @(posedge clk);
    #1;
    if (hold) dat[idx] = 32'h0;
    else vld[idx] = 1'b0;
    check_frame(idx, hold ? 32'h1234_5678 : $urandom);
  endtask

  initial begin
    tbl[0] = '{0, 32'hA5, 8'b10100101, 1'b0};
    tbl[1] = '{1, 32'h81, 8'b10000001, 1'b0};
    tbl[2] = '{0, 32'h07, 8'b11100000, 1'b1};
    tbl[3] = '{0, 32'h03, 8'b11000000, 1'b0};
    tbl[4] = '{1, 32'h3C, 8'b00111100, 1'b0};
    tbl[5] = '{1, 32'hC1, 8'b11000001, 1'b1};
    tbl[6] = '{0, 32'hC1, 8'b10000011, 1'b1};

    vld = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = 32'h0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("reset_noclk", i, outs(i), 4'b1001);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("idle_after_reset", i, outs(i), 4'b1001);
    end

    for (int t = 0; t < 7; t++) begin
      build_table(tbl[t]);
      send(tbl[t].idx, tbl[t].data, 1'b0);
    end

    // Held valid: second word waits for the idle cycle, mid-frame data changes are ignored.
    acc_q.delete();
    build_model(2, 32'hDEAD_BEEF);
    send(2, 32'hDEAD_BEEF, 1'b1);
    build_model(2, 32'h1234_5678);
    @(posedge clk);
    #1 vld[2] = 1'b0;
    check_frame(2, $urandom);
    chk_int("accept_count", acc_q.size(), 2);
    if (acc_q.size() == 2) chk_int("accept_period", acc_q[1] - acc_q[0], 32 + 3 + PAR_BITS);

    // Reset while data bit 4 is on the line.
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 32'hE5;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("bit4_before_reset", 0, outs(0), 4'b0100);
    reset_n = 1'b0;
    #1 chk("reset_midframe", 0, outs(0), 4'b1001);
    repeat (2) begin
      @(negedge clk);
      chk("held_reset", 0, outs(0), 4'b1001);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("after_release", 0, outs(0), 4'b1001);
    build_model(0, 32'h3C);
    send(0, 32'h3C, 1'b0);

    for (int r = 0; r < 30; r++) begin
      int idx;
      logic [31:0] d;
      idx = $urandom_range(0, 2);
      d   = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      build_model(idx, d);
      send(idx, d, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
